core_fetch_buffer: RTL and testbench

Instruction fetch buffer that feeds the decode stage. It accepts 32-bit fetch response words from the instruction memory interface and holds them as halfwords. It presents a halfword-aligned instruction window with 16/32-bit validity flags, PC and fetch-error tags. It retires 2 or 4 bytes per cycle when decode signals eat_2/eat_4, and flushes on control-flow redirect.

---
 rtl/core_fetch_buffer.sv | 128 ++++++++++++
 tb/tb_core_fetch_buffer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/core_fetch_buffer.sv
// Instruction fetch buffer: packs 32-bit fetch words into a halfword queue and
// presents a two-halfword decode window with PC and fetch-error tags.
module core_fetch_buffer #(
  parameter int              BUF_HW   = 4,
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            f_push,
  output logic            f_ready,
  input  logic [31:0]     f_data,
  input  logic            f_hi_only,
  input  logic            f_err,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            s1_16bit,
  output logic            s1_32bit,
  output logic [31:0]     s1_instr,
  output logic [XLEN-1:0] s1_pc,
  output logic [1:0]      s1_ferr,
  input  logic            s2_eat_2,
  input  logic            s2_eat_4
);

  localparam int CW = $clog2(BUF_HW + 1);
  localparam logic [CW-1:0] RDY_MAX = CW'(BUF_HW - 2);

  logic [15:0]       data_q [BUF_HW];
  logic [15:0]       data_d [BUF_HW];
  logic [BUF_HW-1:0] err_q, err_d;
  logic [CW-1:0]     count_q, count_d;
  logic [XLEN-1:0]   pc_q, pc_d;

  logic          c_ge1, c_ge2, is32;
  logic          eat4_ok, eat2_ok, push_ok;
  logic [CW-1:0] eaten, pushed, cnt_after, cnt_after1;

  assign c_ge1 = (count_q != '0);
  assign c_ge2 = (count_q >= CW'(2));
  assign is32  = (data_q[0][1:0] == 2'b11);

  // A lone 32-bit half with a fetch error is still presented so decode can trap.
  assign s1_16bit = c_ge1 && !is32;
  assign s1_32bit = is32 && (c_ge2 || (c_ge1 && err_q[0]));
  assign s1_instr = {(c_ge2 ? data_q[1] : 16'h0), (c_ge1 ? data_q[0] : 16'h0)};
  assign s1_ferr  = {err_q[1] && c_ge2, err_q[0] && c_ge1};
  assign s1_pc    = pc_q;
  assign f_ready  = (count_q <= RDY_MAX);

  always_comb begin
    eat4_ok = s2_eat_4 && s1_32bit;
    eat2_ok = s2_eat_2 && !s2_eat_4 && s1_16bit;
    push_ok = f_push && f_ready;

    eaten = '0;
    if (eat4_ok)      eaten = c_ge2 ? CW'(2) : CW'(1);
    else if (eat2_ok) eaten = CW'(1);

    pushed = '0;
    if (push_ok) pushed = f_hi_only ? CW'(1) : CW'(2);

    cnt_after  = count_q - eaten;
    cnt_after1 = cnt_after + CW'(1);

    for (int i = 0; i < BUF_HW; i++) data_d[i] = data_q[i];
    err_d = err_q;

    // Shift out consumed halfwords one position at a time, ascending order.
    if (eaten != '0) begin
      for (int i = 0; i < BUF_HW - 1; i++) begin
        data_d[i] = data_d[i+1];
        err_d[i]  = err_d[i+1];
      end
    end
    if (eaten == CW'(2)) begin
      for (int i = 0; i < BUF_HW - 1; i++) begin
        data_d[i] = data_d[i+1];
        err_d[i]  = err_d[i+1];
      end
    end

    if (push_ok) begin
      for (int i = 0; i < BUF_HW; i++) begin
        if (CW'(i) == cnt_after) begin
          data_d[i] = f_hi_only ? f_data[31:16] : f_data[15:0];
          err_d[i]  = f_err;
        end else if (!f_hi_only && (CW'(i) == cnt_after1)) begin
          data_d[i] = f_data[31:16];
          err_d[i]  = f_err;
        end
      end
    end

    count_d = cnt_after + pushed;
    pc_d    = pc_q;
    if (eat4_ok)      pc_d = pc_q + XLEN'(4);
    else if (eat2_ok) pc_d = pc_q + XLEN'(2);

    if (flush) begin
      count_d = '0;
      pc_d    = flush_pc & ~XLEN'(1);
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      count_q <= '0;
      pc_q    <= PC_RESET;
      err_q   <= '0;
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  // Halfword payload needs no reset: invalid entries are masked by count.
  always_ff @(posedge g_clk) begin
    for (int i = 0; i < BUF_HW; i++) data_q[i] <= data_d[i];
  end

  a_eat_onehot: assert property (@(posedge g_clk) disable iff (!g_resetn)
    !(s2_eat_2 && s2_eat_4));
  a_push_ready: assert property (@(posedge g_clk) disable iff (!g_resetn)
    !(f_push && !f_ready));

endmodule

// File: tb/tb_core_fetch_buffer.sv
// Bench for core_fetch_buffer: table of per-cycle stimulus with hand-derived
// expected window state, queued when driven and compared after the clock edge.
module tb_core_fetch_buffer;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        f_push, f_hi_only, f_err, flush, s2_eat_2, s2_eat_4;
  logic [31:0] f_data;
  logic [63:0] flush_pc;
  logic        f_ready, s1_16bit, s1_32bit;
  logic [31:0] s1_instr;
  logic [63:0] s1_pc;
  logic [1:0]  s1_ferr;

  int errors = 0;
  int checks = 0;

  always #5 g_clk = ~g_clk;

  core_fetch_buffer #(.BUF_HW(4), .XLEN(64), .PC_RESET(64'h0)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .f_push(f_push), .f_ready(f_ready), .f_data(f_data),
    .f_hi_only(f_hi_only), .f_err(f_err),
    .flush(flush), .flush_pc(flush_pc),
    .s1_16bit(s1_16bit), .s1_32bit(s1_32bit), .s1_instr(s1_instr),
    .s1_pc(s1_pc), .s1_ferr(s1_ferr),
    .s2_eat_2(s2_eat_2), .s2_eat_4(s2_eat_4)
  );

  typedef struct {
    logic        push;
    logic [31:0] data;
    logic        hi;
    logic        err;
    logic        fl;
    logic [63:0] fpc;
    logic        e2;
    logic        e4;
    logic        rdy;
    logic        s16;
    logic        s32;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [1:0]  ferr;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(logic p, logic [31:0] d, logic h, logic e,
                              logic fl, logic [63:0] fp, logic e2, logic e4,
                              logic r, logic s16, logic s32, logic [31:0] ins,
                              logic [63:0] pc, logic [1:0] fe);
    vec_t v;
    v.push = p;  v.data = d;   v.hi = h;    v.err = e;
    v.fl = fl;   v.fpc = fp;   v.e2 = e2;   v.e4 = e4;
    v.rdy = r;   v.s16 = s16;  v.s32 = s32; v.instr = ins;
    v.pc = pc;   v.ferr = fe;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    f_push = 0; f_data = 32'h0; f_hi_only = 0; f_err = 0;
    flush = 0; flush_pc = 64'h0; s2_eat_2 = 0; s2_eat_4 = 0;
  endtask

  task automatic chk_window(string tag, logic r, logic s16, logic s32,
                            logic [31:0] ins, logic [63:0] pc, logic [1:0] fe);
    chk({tag, ".f_ready"},  f_ready,  r);
    chk({tag, ".s1_16bit"}, s1_16bit, s16);
    chk({tag, ".s1_32bit"}, s1_32bit, s32);
    chk({tag, ".s1_instr"}, s1_instr, ins);
    chk({tag, ".s1_pc"},    s1_pc,    pc);
    chk({tag, ".s1_ferr"},  s1_ferr,  fe);
  endtask

  task automatic run_range(int lo, int hi);
    vec_t e;
    for (int k = lo; k <= hi; k++) begin
      @(negedge g_clk);
      f_push = tbl[k].push; f_data = tbl[k].data; f_hi_only = tbl[k].hi;
      f_err = tbl[k].err; flush = tbl[k].fl; flush_pc = tbl[k].fpc;
      s2_eat_2 = tbl[k].e2; s2_eat_4 = tbl[k].e4;
      sb.push_back(tbl[k]);
      @(posedge g_clk);
      #1;
      idle();
      if (sb.size() == 0) begin
        errors++; checks++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 at vec %0d", k);
      end else begin
        e = sb.pop_front();
        chk_window($sformatf("v%0d", k), e.rdy, e.s16, e.s32, e.instr, e.pc, e.ferr);
      end
    end
  endtask

  initial begin
    //                push data         hi e  fl fpc          e2 e4   rdy 16 32 instr          pc        ferr
    tbl.push_back(mk(1, 32'h0001_4501, 0, 0, 0, 64'h0,       0, 0,   1, 1, 0, 32'h0001_4501, 64'h0,    2'b00)); // 0
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 64'h0,       1, 0,   1, 1, 0, 32'h0000_0001, 64'h2,    2'b00));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 64'h0,       1, 0,   1, 0, 0, 32'h0,         64'h4,    2'b00));
    tbl.push_back(mk(1, 32'h00A0_0093, 0, 0, 0, 64'h0,       0, 0,   1, 0, 1, 32'h00A0_0093, 64'h4,    2'b00));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 64'h0,       0, 1,   1, 0, 0, 32'h0,         64'h8,    2'b00));
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 64'h1003,    0, 0,   1, 0, 0, 32'h0,         64'h1002, 2'b00)); // 5
    tbl.push_back(mk(1, 32'h0093_BEEF, 1, 0, 0, 64'h0,       0, 0,   1, 0, 0, 32'h0000_0093, 64'h1002, 2'b00));
    tbl.push_back(mk(1, 32'hDEAD_00A0, 0, 0, 0, 64'h0,       0, 0,   0, 0, 1, 32'h00A0_0093, 64'h1002, 2'b00));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 64'h0,       0, 1,   1, 1, 0, 32'h0000_DEAD, 64'h1006, 2'b00));
    tbl.push_back(mk(1, 32'h1111_2222, 0, 0, 0, 64'h0,       1, 0,   1, 1, 0, 32'h1111_2222, 64'h1008, 2'b00));
    tbl.push_back(mk(1, 32'h3333_4447, 0, 0, 0, 64'h0,       0, 0,   0, 1, 0, 32'h1111_2222, 64'h1008, 2'b00)); // 10
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 64'h0,       1, 0,   0, 1, 0, 32'h4447_1111, 64'h100A, 2'b00));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 64'h0,       1, 0,   1, 0, 1, 32'h3333_4447, 64'h100C, 2'b00));
    tbl.push_back(mk(1, 32'h5555_6663, 0, 0, 0, 64'h0,       0, 1,   1, 0, 1, 32'h5555_6663, 64'h1010, 2'b00));
    tbl.push_back(mk(1, 32'h7777_8881, 0, 0, 0, 64'h0,       1, 0,   0, 0, 1, 32'h5555_6663, 64'h1010, 2'b00));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 64'h0,       0, 1,   1, 1, 0, 32'h7777_8881, 64'h1014, 2'b00)); // 15
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 64'h0,       0, 1,   1, 1, 0, 32'h7777_8881, 64'h1014, 2'b00));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 64'h0,       1, 0,   1, 0, 0, 32'h0000_7777, 64'h1016, 2'b00));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 64'h0,       1, 0,   1, 0, 0, 32'h0000_7777, 64'h1016, 2'b00));
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 64'h2000,    0, 0,   1, 0, 0, 32'h0,         64'h2000, 2'b00));
    tbl.push_back(mk(1, 32'h00A0_0093, 0, 1, 0, 64'h0,       0, 0,   1, 0, 1, 32'h00A0_0093, 64'h2000, 2'b11)); // 20
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 64'h0,       0, 1,   1, 0, 0, 32'h0,         64'h2004, 2'b00));
    tbl.push_back(mk(1, 32'h0073_0000, 1, 1, 0, 64'h0,       0, 0,   1, 0, 1, 32'h0000_0073, 64'h2004, 2'b01));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 64'h0,       0, 1,   1, 0, 0, 32'h0,         64'h2008, 2'b00));
    tbl.push_back(mk(1, 32'h0001_0001, 0, 1, 0, 64'h0,       0, 0,   1, 1, 0, 32'h0001_0001, 64'h2008, 2'b11));
    tbl.push_back(mk(1, 32'h0002_0002, 0, 0, 0, 64'h0,       0, 0,   0, 1, 0, 32'h0001_0001, 64'h2008, 2'b11)); // 25
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 64'h0,       1, 0,   0, 1, 0, 32'h0002_0001, 64'h200A, 2'b01));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 64'h0,       1, 0,   1, 1, 0, 32'h0002_0002, 64'h200C, 2'b00)); // 27
    // after asynchronous reset
    tbl.push_back(mk(1, 32'h0001_4501, 0, 0, 0, 64'h0,       0, 0,   1, 1, 0, 32'h0001_4501, 64'h0,    2'b00)); // 28
    tbl.push_back(mk(1, 32'h1111_2222, 0, 0, 1, 64'h3000,    1, 0,   1, 0, 0, 32'h0,         64'h3000, 2'b00));
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0,
                                                                    1, 0, 0, 32'h0,         64'hFFFF_FFFF_FFFF_FFFE, 2'b00));
    tbl.push_back(mk(1, 32'h0000_0001, 0, 0, 0, 64'h0,       0, 0,   1, 1, 0, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 64'h0,       1, 0,   1, 1, 0, 32'h0,         64'h0,    2'b00)); // 32

    idle();
    g_resetn = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    chk_window("reset", 1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 2'b00);
    @(negedge g_clk);
    g_resetn = 1'b1;

    run_range(0, 27);

    // Buffer holds two halfwords here; drop reset between clock edges.
    #2;
    g_resetn = 1'b0;
    #1;
    chk_window("async_reset", 1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 2'b00);
    @(negedge g_clk);
    g_resetn = 1'b1;

    run_range(28, 32);

    if (sb.size() != 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $fatal(1);
  end

endmodule
